// File: rtl/prog_loader_pkg.sv
// Shared types for the boot loader: loader FSM encodings and the fill word.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        LD_IDLE    = 3'd0,
        LD_LOAD    = 3'd1,
        LD_FILL    = 3'd2,
        LD_RELEASE = 3'd3,
        LD_RUN     = 3'd4,
        LD_DONE    = 3'd5,
        LD_TMO     = 3'd6,
        LD_FAULT   = 3'd7
    } ld_state_e;

    // sll $0,$0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/prog_loader_halt.sv
// Halt detector: flags a PC that has stayed unchanged for HALT_REPEAT consecutive cycles.
module halt_detector #(
    parameter int ADDR_LEN    = 32,
    parameter int HALT_REPEAT = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                en_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    output logic                halt_o
);

    localparam int CW = $clog2(HALT_REPEAT + 1);

    logic [ADDR_LEN-1:0] prev_pc_q, prev_pc_d;
    logic                prev_vld_q, prev_vld_d;
    logic [CW-1:0]       rep_q, rep_d;
    logic                same;

    // The first enabled cycle has no previous PC, so it can never count as a repeat.
    assign same   = prev_vld_q && (pc_i == prev_pc_q);
    assign halt_o = en_i && same && (rep_q == CW'(HALT_REPEAT - 1));

    always_comb begin
        prev_pc_d  = prev_pc_q;
        prev_vld_d = prev_vld_q;
        rep_d      = rep_q;
        if (clr_i) begin
            prev_pc_d  = '0;
            prev_vld_d = 1'b0;
            rep_d      = '0;
        end else if (en_i) begin
            prev_pc_d  = pc_i;
            prev_vld_d = 1'b1;
            if (!same) begin
                rep_d = '0;
            end else if (rep_q != CW'(HALT_REPEAT)) begin
                rep_d = rep_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev_pc_q  <= '0;
            prev_vld_q <= 1'b0;
            rep_q      <= '0;
        end else begin
            prev_pc_q  <= prev_pc_d;
            prev_vld_q <= prev_vld_d;
            rep_q      <= rep_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader and run monitor: streams a program into imem, zero-fills, releases the core, watches for halt/timeout.
// state | meaning: IDLE idle after reset | LOAD accept beats | FILL NOP fill | RELEASE last reset cycle
//                  RUN core running | DONE halted | TMO timed out | FAULT overflow
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTR_LEN   = 32,
    parameter int ADDR_LEN    = 32,
    parameter int PROG_DEPTH  = 64,
    parameter int TIMEOUT     = 1024,
    parameter int HALT_REPEAT = 2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_i,
    input  logic                          ld_valid_i,
    input  logic [INSTR_LEN-1:0]          ld_data_i,
    input  logic                          ld_last_i,
    output logic                          ld_ready_o,
    output logic                          imem_we_o,
    output logic [$clog2(PROG_DEPTH)-1:0] imem_addr_o,
    output logic [INSTR_LEN-1:0]          imem_wdata_o,
    output logic                          cpu_rst_o,
    input  logic [ADDR_LEN-1:0]           pc_i,
    output logic                          done_o,
    output logic                          timeout_o,
    output logic                          err_ovf_o,
    output logic [ADDR_LEN-1:0]           halt_pc_o,
    output logic [$clog2(PROG_DEPTH):0]   words_loaded_o,
    output logic [31:0]                   run_cycles_o
);

    localparam int              AW    = $clog2(PROG_DEPTH);
    localparam int              PW    = AW + 1;
    localparam logic [PW-1:0]   DEPTH = PW'(PROG_DEPTH);
    localparam logic [PW-1:0]   LAST  = PW'(PROG_DEPTH - 1);

    ld_state_e            state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [PW-1:0]        words_q, words_d;
    logic                 we_q, we_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [INSTR_LEN-1:0] wdata_q, wdata_d;
    logic                 cpu_rst_q, cpu_rst_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic                 ovf_q, ovf_d;
    logic [ADDR_LEN-1:0]  hpc_q, hpc_d;
    logic [31:0]          run_q, run_d;
    logic                 ld_ready, accept, halt;

    assign ld_ready = (state_q == LD_LOAD) && (ptr_q < DEPTH);
    assign accept   = ld_ready && ld_valid_i;

    halt_detector #(
        .ADDR_LEN    (ADDR_LEN),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (state_q == LD_RELEASE),
        .en_i   (state_q == LD_RUN),
        .pc_i   (pc_i),
        .halt_o (halt)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        words_d = words_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        ovf_d   = ovf_q;
        hpc_d   = hpc_q;
        run_d   = run_q;
        unique case (state_q)
            LD_IDLE, LD_DONE, LD_TMO, LD_FAULT: begin
                if (start_i) begin
                    state_d = LD_LOAD;
                    ptr_d   = '0;
                    words_d = '0;
                    run_d   = '0;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                    ovf_d   = 1'b0;
                    hpc_d   = '0;
                end
            end
            LD_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q[AW-1:0];
                    wdata_d = ld_data_i;
                    ptr_d   = ptr_q + PW'(1);
                    words_d = words_q + PW'(1);
                    if (ld_last_i) begin
                        state_d = (ptr_q == LAST) ? LD_RELEASE : LD_FILL;
                    end
                end else if (ld_valid_i && (ptr_q == DEPTH)) begin
                    ovf_d   = 1'b1;
                    state_d = LD_FAULT;
                end
            end
            LD_FILL: begin
                we_d    = 1'b1;
                addr_d  = ptr_q[AW-1:0];
                wdata_d = INSTR_LEN'(NOP_INSTR);
                ptr_d   = ptr_q + PW'(1);
                if (ptr_q == LAST) begin
                    state_d = LD_RELEASE;
                end
            end
            LD_RELEASE: state_d = LD_RUN;
            LD_RUN: begin
                if (run_q != '1) begin
                    run_d = run_q + 32'd1;
                end
                // A halt seen in the same cycle the budget runs out still counts as a halt.
                if (halt) begin
                    hpc_d   = pc_i;
                    done_d  = 1'b1;
                    state_d = LD_DONE;
                end else if ({1'b0, run_d} >= 33'(TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = LD_TMO;
                end
            end
            default: state_d = LD_IDLE;
        endcase
        cpu_rst_d = (state_d != LD_RUN);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= LD_IDLE;
            ptr_q     <= '0;
            words_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ovf_q     <= 1'b0;
            hpc_q     <= '0;
            run_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            words_q   <= words_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cpu_rst_q <= cpu_rst_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
            hpc_q     <= hpc_d;
            run_q     <= run_d;
        end
    end

    assign ld_ready_o     = ld_ready;
    assign imem_we_o      = we_q;
    assign imem_addr_o    = addr_q;
    assign imem_wdata_o   = wdata_q;
    assign cpu_rst_o      = cpu_rst_q;
    assign done_o         = done_q;
    assign timeout_o      = tmo_q;
    assign err_ovf_o      = ovf_q;
    assign halt_pc_o      = hpc_q;
    assign words_loaded_o = words_q;
    assign run_cycles_o   = run_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised bench for prog_loader: a transaction-level model predicts every output each cycle.
module tb_prog_loader;

    localparam int IL = 32;
    localparam int AL = 32;
    localparam int D  = 32;
    localparam int TO = 50;
    localparam int HR = 2;
    localparam int AW = 5;

    localparam int P_IDLE = 0, P_LOAD = 1, P_FILL = 2, P_REL = 3;
    localparam int P_RUN  = 4, P_DONE = 5, P_TMO  = 6, P_FAULT = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [IL-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic [AL-1:0] pc = '0;
    logic          ld_ready, imem_we, cpu_rst, done, timeout, err_ovf;
    logic [AW-1:0] imem_addr;
    logic [IL-1:0] imem_wdata;
    logic [AL-1:0] halt_pc;
    logic [AW:0]   words_loaded;
    logic [31:0]   run_cycles;

    always #5 clk = ~clk;

    prog_loader #(
        .INSTR_LEN   (IL),
        .ADDR_LEN    (AL),
        .PROG_DEPTH  (D),
        .TIMEOUT     (TO),
        .HALT_REPEAT (HR)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .ld_valid_i     (ld_valid),
        .ld_data_i      (ld_data),
        .ld_last_i      (ld_last),
        .ld_ready_o     (ld_ready),
        .imem_we_o      (imem_we),
        .imem_addr_o    (imem_addr),
        .imem_wdata_o   (imem_wdata),
        .cpu_rst_o      (cpu_rst),
        .pc_i           (pc),
        .done_o         (done),
        .timeout_o      (timeout),
        .err_ovf_o      (err_ovf),
        .halt_pc_o      (halt_pc),
        .words_loaded_o (words_loaded),
        .run_cycles_o   (run_cycles)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_phase = P_IDLE;
    int            m_ptr = 0, m_words = 0, m_addr = 0;
    longint        m_run = 0;
    logic [AL-1:0] m_hpc = '0;
    logic [IL-1:0] m_wdata = '0;
    bit            m_done = 0, m_tmo = 0, m_ovf = 0, m_we = 0, m_acc = 0;
    logic [AL-1:0] pcs[$];
    int            cyc = 0;

    function automatic bit window_halted();
        if (pcs.size() != HR + 1) return 1'b0;
        foreach (pcs[i]) if (pcs[i] !== pcs[0]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc++;
        m_we  = 0;
        m_acc = 0;
        if (!rst_n) begin
            m_phase = P_IDLE; m_ptr = 0; m_words = 0; m_run = 0; m_hpc = '0;
            m_done = 0; m_tmo = 0; m_ovf = 0; m_addr = 0; m_wdata = '0;
            pcs.delete();
        end else begin
            case (m_phase)
                P_IDLE, P_DONE, P_TMO, P_FAULT: if (start) begin
                    m_phase = P_LOAD; m_ptr = 0; m_words = 0; m_run = 0; m_hpc = '0;
                    m_done = 0; m_tmo = 0; m_ovf = 0;
                end
                P_LOAD: begin
                    if (ld_valid && m_ptr < D) begin
                        m_acc = 1; m_we = 1; m_addr = m_ptr; m_wdata = ld_data;
                        m_words++;
                        if (ld_last) m_phase = (m_ptr == D - 1) ? P_REL : P_FILL;
                        m_ptr++;
                    end else if (ld_valid) begin
                        m_ovf = 1; m_phase = P_FAULT;
                    end
                end
                P_FILL: begin
                    m_we = 1; m_addr = m_ptr; m_wdata = '0;
                    if (m_ptr == D - 1) m_phase = P_REL;
                    m_ptr++;
                end
                P_REL: begin
                    m_phase = P_RUN;
                    pcs.delete();
                end
                P_RUN: begin
                    if (m_run < 64'hFFFF_FFFF) m_run++;
                    pcs.push_back(pc);
                    if (pcs.size() > HR + 1) void'(pcs.pop_front());
                    if (window_halted()) begin
                        m_hpc = pc; m_done = 1; m_phase = P_DONE;
                    end else if (m_run >= TO) begin
                        m_tmo = 1; m_phase = P_TMO;
                    end
                end
                default: m_phase = P_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [IL-1:0] mem_dut[D];
    logic [IL-1:0] prog[64];

    always @(negedge clk) begin
        chk("cpu_rst", cpu_rst, m_phase != P_RUN);
        chk("ld_ready", ld_ready, (m_phase == P_LOAD) && (m_ptr < D));
        chk("imem_we", imem_we, m_we);
        if (m_we || m_phase == P_IDLE) begin
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wdata", imem_wdata, m_wdata);
        end
        chk("done", done, m_done);
        chk("timeout", timeout, m_tmo);
        chk("err_ovf", err_ovf, m_ovf);
        chk("halt_pc", halt_pc, m_hpc);
        chk("words_loaded", words_loaded, m_words);
        chk("run_cycles", run_cycles, m_run);
        if (imem_we) mem_dut[imem_addr] = imem_wdata;
    end

    // ---------------- stimulus helpers ----------------
    int            t_first = 0;
    logic [AL-1:0] pc_seq[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // vmode: 0 always valid, 1 toggle 1/0, 2 random; stop early once abort_at beats are accepted
    task automatic load(input int n, input bit has_last, input int vmode, input int abort_at);
        int idx = 0;
        int c = 0;
        bit v;
        foreach (mem_dut[i]) mem_dut[i] = 'x;
        for (int i = 0; i < 64; i++) prog[i] = $urandom;
        while (idx < n && c < 400) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (c % 2 == 0) : 1'($urandom_range(0, 1));
            ld_valid = v;
            ld_data  = v ? prog[idx] : $urandom;
            ld_last  = v && has_last && (idx == n - 1);
            tick();
            c++;
            if (m_acc) begin
                if (idx == 0) t_first = cyc;
                idx++;
            end
            if (m_phase != P_LOAD) break;
            if (abort_at > 0 && idx == abort_at) break;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        if (c >= 400) chk("load_budget", c, 0);
    endtask

    task automatic wait_phase(input int p, input int budget, input string nm);
        int c = 0;
        while (m_phase != p && c < budget) begin
            tick();
            c++;
        end
        chk(nm, m_phase, p);
    endtask

    task automatic run_pc(input int budget);
        int c = 0;
        while (m_phase == P_RUN && c < budget) begin
            if (pc_seq.size() > 0) pc = pc_seq.pop_front();
            tick();
            c++;
        end
    endtask

    task automatic check_mem(input int n);
        for (int i = 0; i < D; i++)
            chk($sformatf("mem[%0d]", i), mem_dut[i], (i < n) ? prog[i] : 32'h0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_ld_ready"}, ld_ready, 0);
        chk({tag, "_imem_we"}, imem_we, 0);
        chk({tag, "_imem_addr"}, imem_addr, 0);
        chk({tag, "_imem_wdata"}, imem_wdata, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_err_ovf"}, err_ovf, 0);
        chk({tag, "_halt_pc"}, halt_pc, 0);
        chk({tag, "_words"}, words_loaded, 0);
        chk({tag, "_run"}, run_cycles, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        int n;
        logic [AL-1:0] r;
        rst_n = 1'b0;
        repeat (3) tick();
        chk_reset_vals("por");
        rst_n = 1'b1;
        tick();

        // 24 back-to-back words, then halt at pc 8
        pulse_start();
        chk("ready_after_start", ld_ready, 1);
        load(24, 1, 0, 0);
        wait_phase(P_RUN, 50, "reach_run_t1");
        // beat presented in the cycle ending at t_first; cpu_rst low in the cycle starting at cyc
        chk("rst_fall_latency", cyc - t_first + 1, 33);
        chk("cpu_rst_low_first_run", cpu_rst, 0);
        check_mem(24);
        chk("words_24", words_loaded, 24);
        pc = '0;
        pc_seq = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8};
        run_pc(20);
        chk("halt_done", done, 1);
        chk("halt_pc_8", halt_pc, 8);
        chk("halt_no_tmo", timeout, 0);
        chk("halt_run_cycles", run_cycles, 5);

        // stalled stream from DONE, then timeout
        n = $urandom_range(8, 20);
        pulse_start();
        load(n, 1, 1, 0);
        wait_phase(P_RUN, 50, "reach_run_t2");
        check_mem(n);
        pc_seq.delete();
        for (int i = 0; i < 60; i++) pc_seq.push_back(AL'(i * 4));
        run_pc(100);
        chk("tmo_flag", timeout, 1);
        chk("tmo_run_cycles", run_cycles, 50);
        chk("tmo_no_done", done, 0);

        // overflow: 33 words, no last
        pulse_start();
        load(33, 0, 0, 0);
        chk("ovf_flag", err_ovf, 1);
        chk("ovf_words", words_loaded, 32);
        repeat (4) tick();
        chk("ovf_cpu_rst", cpu_rst, 1);

        // reset mid-load after word 10
        pulse_start();
        load(30, 1, 2, 10);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("rst_load");
        rst_n = 1'b1;
        tick();

        // full-depth program (no fill), then reset mid-run
        pulse_start();
        load(32, 1, 2, 0);
        wait_phase(P_RUN, 10, "reach_run_full");
        check_mem(32);
        pc_seq.delete();
        for (int i = 0; i < 6; i++) pc_seq.push_back(AL'(i * 4 + 16));
        run_pc(6);
        chk("still_running", cpu_rst, 0);
        rst_n = 1'b0;
        tick();
        chk_reset_vals("rst_run");
        rst_n = 1'b1;
        tick();

        // single word, start held into LOAD (ignored), halt at random pc
        start = 1'b1;
        tick();
        ld_valid = 1'b0;
        tick();
        start = 1'b0;
        load(1, 1, 2, 0);
        wait_phase(P_RUN, 50, "reach_run_one");
        check_mem(1);
        chk("words_1", words_loaded, 1);
        r = AL'({$urandom_range(1, 1000), 2'b00});
        pc_seq = '{32'd0, r, r, r};
        run_pc(20);
        chk("halt2_done", done, 1);
        chk("halt2_pc", halt_pc, r);
        chk("halt2_run_cycles", run_cycles, 4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Parametrised boot-loader and run monitor for the single-cycle CPU. It holds the core in reset and streams a program of up to `PROG_DEPTH` words into instruction memory over a valid/ready port, then zero-fills the rest of memory with NOPs. It then releases the core and watches `pc_out` until it sees a self-loop halt or a cycle timeout. It replaces hierarchical `imem[]` pokes from benches and is synthesisable for FPGA bring-up.

## Interface
- `INSTR_LEN`, 32, instruction word width
- `ADDR_LEN`, 32, CPU PC width
- `PROG_DEPTH`, 64, instruction-memory depth in words (power of two, ≥2)
- `TIMEOUT`, 1024, maximum RUN cycles before timeout (≥1)
- `HALT_REPEAT`, 2, consecutive cycles with unchanged PC that count as a halt (≥1)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse: begin load (honoured in IDLE, DONE, TMO and FAULT only)
- `ld_valid`  in  1  load beat valid
- `ld_data`  in  INSTR_LEN  instruction word
- `ld_last`  in  1  marks the final program word (qualified by `ld_valid`)
- `ld_ready`  out  1  loader accepts a beat
- `imem_we`  out  1  instruction-memory write enable
- `imem_addr`  out  $clog2(PROG_DEPTH)  word address
- `imem_wdata`  out  INSTR_LEN  write data
- `cpu_rst`  out  1  active-high reset to the CPU core
- `pc_in`  in  ADDR_LEN  CPU `pc_out`
- `done`  out  1  halt detected
- `timeout`  out  1  `TIMEOUT` reached without a halt
- `err_ovf`  out  1  beat offered at `PROG_DEPTH` words with no `ld_last`
- `halt_pc`  out  ADDR_LEN  PC at halt
- `words_loaded`  out  $clog2(PROG_DEPTH)+1  accepted program words
- `run_cycles`  out  32  RUN cycle count, saturating at all-ones

## Operation
- States: IDLE, LOAD, FILL, RELEASE, RUN, DONE, TMO, FAULT.
- IDLE:
  - `cpu_rst`=1.
  - `start` → LOAD; `words_loaded`, `run_cycles` and `err_ovf` clear and the write pointer goes to 0.
- LOAD:
  - `ld_ready`=1 while the pointer < PROG_DEPTH.
  - A beat is accepted on `ld_valid & ld_ready`. It writes `ld_data` to the pointer address, then the pointer increments.
  - Accepted beat with `ld_last`: if the pointer was PROG_DEPTH-1 → RELEASE, else → FILL.
  - Pointer = PROG_DEPTH with `ld_valid`=1 and no accepted last beat: `err_ovf`=1, → FAULT.
- FILL:
  - Writes `32'h0000_0000` (sll $0,$0,0) to each remaining address, one per cycle.
  - After the write to PROG_DEPTH-1 → RELEASE.
  - `ld_ready`=0.
- RELEASE: one cycle with `cpu_rst`=1, → RUN.
- RUN:
  - `cpu_rst`=0 and `run_cycles` increments each cycle.
  - A halt is `pc_in` equal to its previous-cycle value for HALT_REPEAT consecutive cycles. On a halt: `halt_pc`←`pc_in`, `done`=1, → DONE.
  - If `run_cycles` reaches TIMEOUT first → TMO with `timeout`=1. If both occur in the same cycle, the halt wins.
- DONE, TMO and FAULT:
  - `cpu_rst`=1 and status outputs are held.
  - `start` → LOAD, clearing the status outputs.
- `rst`=0 in any state, including mid-LOAD and mid-RUN, on the next edge:
  - state → IDLE, `cpu_rst`=1;
  - `imem_we`, `ld_ready`, `done`, `timeout`, `err_ovf` → 0;
  - `halt_pc`, `words_loaded`, `run_cycles`, `imem_addr`, `imem_wdata` → 0.
  - Memory contents are untouched.
- A `start` arriving in LOAD, FILL, RELEASE or RUN is ignored.

## Timing
- All outputs are registered except `ld_ready`, which decodes state and pointer.
- A write lands one cycle after beat acceptance: `imem_we`/`imem_addr`/`imem_wdata` are valid for exactly one cycle.
- Back-to-back beats give one write per cycle, with no bubbles.
- After the `start` edge, `ld_ready` is high from the next cycle.
- `cpu_rst` falls on the first RUN cycle.
- Load of N words with zero-fill: LOAD N cycles, FILL PROG_DEPTH−N cycles, RELEASE 1 cycle.
- The first RUN cycle sees `pc_in`=0.
- `done` rises HALT_REPEAT cycles after the first repeated PC.

## Structure
- Additions to `defines.v`:
  - state encodings `LD_IDLE` … `LD_FAULT`, 3 bits;
  - `` `NOP_INSTR `` 32'h0000_0000.
- One sub-module, `halt_detector`, containing:
  - the previous-PC register;
  - the repeat counter;
  - a `halt` pulse output.
- The FSM, counters and write port live in `prog_loader`.

## Test plan
- PROG_DEPTH=32. Load 24 words back-to-back, `ld_last` on the 24th. Required: 24 writes to addresses 0–23, then 8 zero writes to 24–31, `words_loaded`=24, `cpu_rst` falls 33 cycles after the first accepted beat.
- Stall the stream by toggling `ld_valid` 1/0 on every cycle. Required: writes occur only after accepted beats, and the address sequence is unbroken.
- `pc_in` runs 0,4,8,8,8. Required: `done`=1 and `halt_pc`=8 with HALT_REPEAT=2; `timeout` stays 0.
- `pc_in` increments every cycle with TIMEOUT=50. Required: `timeout`=1 and `run_cycles`=50 in TMO.
- Offer 33 words with no `ld_last` at PROG_DEPTH=32. Required: `err_ovf`=1 and state FAULT, and `cpu_rst` stays 1.
- Assert `rst`=0 mid-LOAD (word 10) and mid-RUN. Required: every output takes its reset value on the next edge. A following `start` reloads cleanly.
